// File: rtl/bf_sdf_stage.sv
// Radix-2 single-delay-feedback butterfly stage: buffers the first half of each
// 2*DEPTH block, then emits x[k]+x[k+DEPTH] and, one block later, x[k]-x[k+DEPTH].
// Optional macro BF_SCALE_EN rounds every result by (r+1)>>>1.
module bf_sdf_stage #(
    parameter int BW    = 16,
    parameter int DEPTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [BW-1:0] in_real,
    input  logic signed [BW-1:0] in_imag,
    output logic                 out_valid,
    output logic signed [BW:0]   out_real,
    output logic signed [BW:0]   out_imag,
    output logic                 out_half
);

    localparam int CW = $clog2(2 * DEPTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(2 * DEPTH - 1);

    typedef logic signed [BW:0]   samp_t;
    typedef logic signed [BW+1:0] wide_t;

    // Results are formed one bit wider than needed so the rounding add cannot wrap.
    function automatic samp_t shape(input wide_t r);
`ifdef BF_SCALE_EN
        wide_t t;
        t = (r + $signed({{(BW + 1){1'b0}}, 1'b1})) >>> 1;
        return samp_t'(t);
`else
        return samp_t'(r);
`endif
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic          primed_q, primed_d;
    samp_t         dl_re_q [DEPTH];
    samp_t         dl_im_q [DEPTH];
    samp_t         dl_re_d [DEPTH];
    samp_t         dl_im_d [DEPTH];
    logic          out_valid_q, out_valid_d;
    samp_t         out_real_q, out_real_d;
    samp_t         out_imag_q, out_imag_d;
    logic          out_half_q, out_half_d;

    logic  phase;
    samp_t head_re, head_im;
    wide_t in_re_x, in_im_x, hd_re_x, hd_im_x;
    samp_t p_re, p_im, m_re, m_im;
    samp_t push_re, push_im;

    always_comb begin
        phase   = cnt_q[CW-1];
        head_re = dl_re_q[DEPTH-1];
        head_im = dl_im_q[DEPTH-1];
        in_re_x = {{2{in_real[BW-1]}}, in_real};
        in_im_x = {{2{in_imag[BW-1]}}, in_imag};
        hd_re_x = {head_re[BW], head_re};
        hd_im_x = {head_im[BW], head_im};
        p_re    = shape(hd_re_x + in_re_x);
        p_im    = shape(hd_im_x + in_im_x);
        m_re    = shape(hd_re_x - in_re_x);
        m_im    = shape(hd_im_x - in_im_x);
        push_re = phase ? m_re : {in_real[BW-1], in_real};
        push_im = phase ? m_im : {in_imag[BW-1], in_imag};
    end

    always_comb begin
        cnt_d       = cnt_q;
        primed_d    = primed_q;
        dl_re_d     = dl_re_q;
        dl_im_d     = dl_im_q;
        out_valid_d = 1'b0;
        out_real_d  = out_real_q;
        out_imag_d  = out_imag_q;
        out_half_d  = out_half_q;
        if (in_valid) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_MAX) begin
                primed_d = 1'b1;
            end
            for (int i = DEPTH - 1; i > 0; i--) begin
                dl_re_d[i] = dl_re_q[i-1];
                dl_im_d[i] = dl_im_q[i-1];
            end
            dl_re_d[0]  = push_re;
            dl_im_d[0]  = push_im;
            out_valid_d = phase | primed_q;
            out_half_d  = ~phase;
            out_real_d  = phase ? p_re : head_re;
            out_imag_d  = phase ? p_im : head_im;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_real_q  <= '0;
            out_imag_q  <= '0;
            out_half_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                dl_re_q[i] <= '0;
                dl_im_q[i] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            out_valid_q <= out_valid_d;
            out_real_q  <= out_real_d;
            out_imag_q  <= out_imag_d;
            out_half_q  <= out_half_d;
            dl_re_q     <= dl_re_d;
            dl_im_q     <= dl_im_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_real  = out_real_q;
    assign out_imag  = out_imag_q;
    assign out_half  = out_half_q;

endmodule

// File: tb/tb_bf_sdf_stage.sv
// Self-checking bench for bf_sdf_stage (BW=16, DEPTH=4) against a block-level
// model of the butterfly stream; define BF_SCALE_EN to check the scaled build.
module tb_bf_sdf_stage;

   localparam int BW = 16;
   localparam int D  = 4;

   logic                 clk;
   logic                 rst;
   logic                 in_valid;
   logic signed [BW-1:0] in_real;
   logic signed [BW-1:0] in_imag;
   logic                 out_valid;
   logic signed [BW:0]   out_real;
   logic signed [BW:0]   out_imag;
   logic                 out_half;

   int total = 0;
   int bad   = 0;

   // Accepted samples since the last reset, plus the expected held outputs.
   int xr[$];
   int xi[$];
   int expRe = 0;
   int expIm = 0;
   int expHalf = 0;

   bf_sdf_stage #(.BW(BW), .DEPTH(D)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_real(in_real),
      .in_imag(in_imag),
      .out_valid(out_valid),
      .out_real(out_real),
      .out_imag(out_imag),
      .out_half(out_half)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Result shaping as seen from outside: optional round-half-up halving.
   function automatic int scl(input int r);
`ifdef BF_SCALE_EN
      return (r + 1) >>> 1;
`else
      return r;
`endif
   endfunction

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string tag, input int got, input int want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("[TB] FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   // Compares all four outputs with the model's expectation.
   task automatic checkAll(input string tag, input int expValid);
      checkOutput({tag, ".valid"}, int'(out_valid), expValid);
      checkOutput({tag, ".real"}, int'(out_real), expRe);
      checkOutput({tag, ".imag"}, int'(out_imag), expIm);
      checkOutput({tag, ".half"}, int'(out_half), expHalf);
   endtask

   // Drives one cycle of input, predicts the output from the stream history,
   // then checks the registered result one cycle later.
   task automatic applyStimulus(input string tag, input bit v, input int re, input int im);
      int n;
      int b;
      int p;
      int ev;
      in_valid = v;
      in_real  = 16'(re);
      in_imag  = 16'(im);
      ev = 0;
      if (v) begin
         xr.push_back(re);
         xi.push_back(im);
         n = xr.size() - 1;
         b = n / (2 * D);
         p = n % (2 * D);
         if (p >= D) begin
            expRe   = scl(xr[n-D] + re);
            expIm   = scl(xi[n-D] + im);
            expHalf = 0;
            ev      = 1;
         end else begin
            expHalf = 1;
            if (b == 0) begin
               expRe = 0;
               expIm = 0;
            end else begin
               expRe = scl(xr[n-2*D] - xr[n-D]);
               expIm = scl(xi[n-2*D] - xi[n-D]);
               ev    = 1;
            end
         end
      end
      @(posedge clk);
      #1;
      checkAll(tag, ev);
   endtask

   // Asynchronous reset: outputs must clear without waiting for a clock edge.
   task automatic doReset();
      rst      = 1'b1;
      in_valid = 1'b0;
      in_real  = '0;
      in_imag  = '0;
      #1;
      xr.delete();
      xi.delete();
      expRe   = 0;
      expIm   = 0;
      expHalf = 0;
      checkAll("reset", 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Directed scenarios followed by randomized blocks with random gaps.
   initial begin
      doReset();

      $display("[TB] basic block");
      for (int i = 1; i <= 8; i++) applyStimulus("basic", 1'b1, i, 0);
      for (int i = 0; i < 4; i++) applyStimulus("basicM", 1'b1, 0, 0);
      applyStimulus("idle", 1'b0, 0, 0);

      $display("[TB] gaps");
      @(posedge clk);
      #1;
      doReset();
      for (int i = 1; i <= 8; i++) begin
         applyStimulus("gapIn", 1'b1, i, 0);
         applyStimulus("gapIdle", 1'b0, 0, 0);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus("gapM", 1'b1, 0, 0);
         applyStimulus("gapIdle", 1'b0, 0, 0);
      end

      $display("[TB] extremes");
      doReset();
      applyStimulus("ext", 1'b1, 32767, -32768);
      for (int i = 0; i < 3; i++) applyStimulus("ext", 1'b1, 0, 0);
      applyStimulus("extP0", 1'b1, 32767, 32767);
      for (int i = 0; i < 3; i++) applyStimulus("ext", 1'b1, 0, 0);
      applyStimulus("extM0", 1'b1, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus("ext", 1'b1, 0, 0);

      $display("[TB] reset mid-block");
      doReset();
      for (int i = 1; i <= 6; i++) applyStimulus("pre", 1'b1, i, 0);
      doReset();
      for (int i = 1; i <= 8; i++) applyStimulus("post", 1'b1, i, 0);
      for (int i = 0; i < 4; i++) applyStimulus("postM", 1'b1, 0, 0);

      $display("[TB] random blocks");
      doReset();
      for (int i = 0; i < 6 * 2 * D; i++) begin
         if ($urandom_range(0, 3) == 0) applyStimulus("rndIdle", 1'b0, 0, 0);
         applyStimulus("rnd", 1'b1, int'($urandom_range(0, 65535)) - 32768,
                       int'($urandom_range(0, 65535)) - 32768);
      end
      for (int i = 0; i < D; i++) applyStimulus("rndFlush", 1'b1, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
